// File: rtl/data_mem_slave.sv
// data_mem_slave
// Word-organised data memory behind the CPU store/load bridge.
// After every reset a clear sweep zeroes the whole array, one word per
// cycle, while busy is high. Once READY, accesses behave as follows:
//   - Reads are combinational and return the full word.
//   - Legal byte-masked writes commit at the clock edge.
//   - Each commit is reported on a one-cycle trace port (log_*).
//   - A nonzero byte mask that is not a legal write raises err for one cycle.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset          synchronous active-high reset, restarts the clear sweep
//   m_data_addr    byte address (bits [1:0] ignored for data selection)
//   m_data_wdata   lane-replicated write data
//   m_data_byteen  byte-lane write enables, 4'b0000 = no write
//   m_inst_addr    PC of the accessing instruction (trace only)
//   m_data_rdata   full word at the addressed location, 0 when not readable
//   busy           high while the clear sweep runs
//   log_valid      one-cycle pulse per committed write
//   log_pc         PC of the committed write
//   log_addr       word-aligned address of the committed write
//   log_data       merged word that was written
//   err            one-cycle pulse per rejected write
module data_mem_slave #(
    parameter int DEPTH = 3072,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        busy,
    output logic        log_valid,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        err
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [31:0]      BYTE_LIMIT = 32'(4 * DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_clr_we;

    logic [31:0]      r_mem [DEPTH];

    logic             r_log_valid;
    logic [31:0]      r_log_pc;
    logic [31:0]      r_log_addr;
    logic [31:0]      r_log_data;
    logic             r_err;

    logic             w_ready;
    logic             w_in_range;
    logic [IDX_W-1:0] w_aidx;
    logic [31:0]      w_word;
    logic [31:0]      w_merged;
    logic             w_be_ok;
    logic             w_wr_ok;
    logic             w_wr_bad;

    assign w_ready    = (r_state == S_READY);
    assign w_in_range = (m_data_addr < BYTE_LIMIT);
    assign w_aidx     = m_data_addr[IDX_W+1:2];
    // Out-of-range indices may be looked up here, but the result is never
    // used: both the read mux and the write enable require w_in_range.
    assign w_word     = r_mem[w_aidx];

    // Only naturally aligned byte, halfword and word masks are accepted.
    always_comb begin
        w_be_ok = 1'b0;
        case (m_data_byteen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
            default:                   w_be_ok = 1'b0;
        endcase
    end

    assign w_wr_ok  = w_ready & w_be_ok & w_in_range;
    assign w_wr_bad = w_ready & (m_data_byteen != 4'b0000) & ~w_wr_ok;

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    // Reads return the stored (pre-write) word; the merge lands at the edge.
    assign m_data_rdata = (w_ready && w_in_range) ? w_word : 32'h0;
    assign busy         = ~w_ready;

    // FSM: next state and sweep index
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_clr_we    = 1'b0;
        if (r_state == S_CLEAR) begin
            w_clr_we = 1'b1;
            if (r_idx == LAST_IDX) begin
                w_state_nxt = S_READY;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Memory array: sweep clear or merged write, never on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_we) begin
                r_mem[r_idx] <= 32'h0;
            end else if (w_wr_ok) begin
                r_mem[w_aidx] <= w_merged;
            end
        end
    end

    // Trace and error pulses; trace payload holds between commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_log_valid <= 1'b0;
            r_log_pc    <= 32'h0;
            r_log_addr  <= 32'h0;
            r_log_data  <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_log_valid <= w_wr_ok;
            r_err       <= w_wr_bad;
            if (w_wr_ok) begin
                r_log_pc   <= m_inst_addr;
                r_log_addr <= {m_data_addr[31:2], 2'b00};
                r_log_data <= w_merged;
            end
        end
    end

    assign log_valid = r_log_valid;
    assign log_pc    = r_log_pc;
    assign log_addr  = r_log_addr;
    assign log_data  = r_log_data;
    assign err       = r_err;

endmodule
